// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 device-to-host receiver.
// Frame bit numbering counts from the first bit after the start bit:
// bits 0..7 are data (LSB first), bit 8 is odd parity, bit 9 is the stop bit.
package ps2_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } ps2_state_t;

    // Start + 8 data + parity + stop.
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_PARITY_BIT = 8;
    localparam int PS2_STOP_BIT   = 9;

    // Wide enough to count every bit position of a frame.
    localparam int PS2_BIT_CNT_W  = $clog2(PS2_FRAME_BITS);

    // Observable receiver status, exported for checkers and debug.
    typedef struct packed {
        ps2_state_t                 state;
        logic                       clock_level;
        logic                       parity_bit;
        logic [PS2_BIT_CNT_W-1:0]   bit_count;
    } ps2_debug_t;

    // Odd parity: the data byte plus its parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_frame_receiver_filter.sv
// ps2_input_filter: 2-flop synchronizer plus glitch filter for one
// asynchronous PS/2 line. The filtered level follows the synchronized input
// only once FILTER_LENGTH consecutive samples disagree with the current
// filtered level; shorter pulses never reach the output. o_fall is a
// registered one-cycle strobe that is high in the first cycle the filtered
// level reads 0 after having been 1.
module ps2_input_filter #(
    parameter int FILTER_LENGTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LENGTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(FILTER_LENGTH - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_count;
    logic          r_fall;

    // Two-stage synchronizer; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Run-length filter: count disagreeing samples, flip level on the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= 1'b1;
            r_count <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_count == LAST_COUNT) begin
                    r_level <= r_sync2;
                    r_count <= '0;
                    // Level is about to go 1 -> 0 exactly when it is 1 now.
                    r_fall  <= r_level;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else begin
                // Any agreeing sample restarts the run, which kills glitches.
                r_count <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: deserializes PS/2 device-to-host frames.
//
// Output handshake: dataReady is a valid-only strobe with no ready/back
// pressure. It is high for exactly one cycle, and dataOut carries the new byte
// in that same cycle and holds it until the next dataReady. frameError is a
// one-cycle strobe for a discarded frame; the two strobes never coincide.
//
// Optional build macro PS2_FRAME_RECEIVER_PARITY_CHECK_EN: when defined, a
// parity mismatch discards the frame with frameError. When undefined the
// parity bit is sampled (visible in debugStatus) but does not affect the result.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LENGTH  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clock,
    input  logic       ps2Data,
    output logic       dataReady,
    output logic [7:0] dataOut,
    output logic       frameError,
    output ps2_debug_t debugStatus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [PS2_BIT_CNT_W-1:0] PARITY_IDX = PS2_BIT_CNT_W'(PS2_PARITY_BIT);
    localparam logic [PS2_BIT_CNT_W-1:0] STOP_IDX   = PS2_BIT_CNT_W'(PS2_STOP_BIT);

    logic                     w_clk_level;
    logic                     w_fall;
    logic                     w_sample_data;
    logic                     w_parity_ok;

    logic                     r_dsync1;
    logic                     r_dsync2;
    logic [FILTER_LENGTH-1:0] r_data_dly;

    ps2_state_t               r_state;
    logic [PS2_BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]               r_shift;
    logic                     r_parity;
    logic [TW-1:0]            r_timeout;
    logic                     r_data_ready;
    logic                     r_frame_error;
    logic [7:0]               r_data_out;

    ps2_input_filter #(
        .FILTER_LENGTH (FILTER_LENGTH)
    ) u_clock_filter (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (ps2Clock),
        .o_level (w_clk_level),
        .o_fall  (w_fall)
    );

    // Synchronize data, then delay it so a falling-edge strobe sees the data
    // level from the cycle the clock transition first left the synchronizer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dsync1   <= 1'b1;
            r_dsync2   <= 1'b1;
            r_data_dly <= '1;
        end else begin
            r_dsync1   <= ps2Data;
            r_dsync2   <= r_dsync1;
            r_data_dly <= {r_data_dly[FILTER_LENGTH-2:0], r_dsync2};
        end
    end

    assign w_sample_data = r_data_dly[FILTER_LENGTH-1];

`ifdef PS2_FRAME_RECEIVER_PARITY_CHECK_EN
    assign w_parity_ok = odd_parity_ok(r_shift, r_parity);
`else
    assign w_parity_ok = 1'b1;
`endif

    // Frame FSM: start detection, bit shifting, stop/parity check, timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_timeout     <= '0;
            r_data_ready  <= 1'b0;
            r_frame_error <= 1'b0;
            r_data_out    <= 8'h00;
        end else begin
            r_data_ready  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timeout <= '0;
                    // A falling edge with data high is line noise, not a start.
                    if (w_fall && !w_sample_data) begin
                        r_state   <= RECEIVE;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                RECEIVE: begin
                    if (w_fall) begin
                        r_timeout <= '0;
                        if (r_bit_cnt < PARITY_IDX) begin
                            // LSB arrives first, so shift in from the top.
                            r_shift   <= {w_sample_data, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + PS2_BIT_CNT_W'(1);
                        end else if (r_bit_cnt == PARITY_IDX) begin
                            r_parity  <= w_sample_data;
                            r_bit_cnt <= r_bit_cnt + PS2_BIT_CNT_W'(1);
                        end else begin
                            // Stop bit: bit count is STOP_IDX here.
                            r_state   <= IDLE;
                            r_bit_cnt <= '0;
                            if (w_sample_data && w_parity_ok) begin
                                r_data_ready <= 1'b1;
                                r_data_out   <= r_shift;
                            end else begin
                                r_frame_error <= 1'b1;
                            end
                        end
                    end else if (r_timeout == TIMEOUT_LIMIT) begin
                        // Device stopped clocking mid-frame: drop the partial byte.
                        r_frame_error <= 1'b1;
                        r_state       <= IDLE;
                        r_bit_cnt     <= '0;
                        r_shift       <= '0;
                        r_timeout     <= '0;
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dataReady  = r_data_ready;
    assign frameError = r_frame_error;
    assign dataOut    = r_data_out;

    assign debugStatus.state       = r_state;
    assign debugStatus.clock_level = w_clk_level;
    assign debugStatus.parity_bit  = r_parity;
    assign debugStatus.bit_count   = r_bit_cnt;

    // STOP_IDX documents the last frame position; the FSM reaches it implicitly.
    logic w_unused_stop_idx;
    assign w_unused_stop_idx = ^STOP_IDX;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: drives PS/2 frames on the raw pins, predicts each
// frame's outcome from the frame's contents, and checks every strobe.
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int FL      = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 40;

  logic       clock;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       data_ready;
  logic [7:0] data_out;
  logic       frame_error;
  ps2_debug_t debug_status;

  int n_vec;
  int n_err;

  // {is_error, dataOut} expected at each strobe
  logic [8:0] exp_q[$];
  logic [7:0] model_dout;

  ps2_frame_receiver #(
    .FILTER_LENGTH  (FL),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2Clock    (ps2_clk),
    .ps2Data     (ps2_data),
    .dataReady   (data_ready),
    .dataOut     (data_out),
    .frameError  (frame_error),
    .debugStatus (debug_status)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h, expected %03h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  // driver: send the first nbits of bits[] (bit 0 = start), device style
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      repeat (HALF / 2) @(negedge clock);
      ps2_data = bits[i];
      if (glitch) begin
        repeat (4) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (HALF / 2 - 4 - (FL - 1)) @(negedge clock);
      end else begin
        repeat (HALF / 2) @(negedge clock);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
    repeat (HALF / 2) @(negedge clock);
    ps2_data = 1'b1;
  endtask

  // reference model + stimulus: predict the outcome, queue it, drive the frame
  task automatic issue_frame(input logic [7:0] b, input logic par, input logic stop,
                             input logic start, input int nbits, input bit glitch);
    logic [10:0] bits;
    bit          parity_good;
    bits        = {stop, par, b, start};
    parity_good = (($countones(b) + int'(par)) % 2) == 1;
    if (start == 1'b0) begin
      if (nbits < PS2_FRAME_BITS) begin
        exp_q.push_back({1'b1, model_dout});
      end else if (stop == 1'b0) begin
        exp_q.push_back({1'b1, model_dout});
`ifdef PS2_FRAME_RECEIVER_PARITY_CHECK_EN
      end else if (!parity_good) begin
        exp_q.push_back({1'b1, model_dout});
`endif
      end else begin
        model_dout = b;
        exp_q.push_back({1'b0, b});
      end
    end
    send_bits(bits, nbits, glitch);
    if (start == 1'b0 && nbits < PS2_FRAME_BITS)
      repeat (TIMEOUT + 10) @(negedge clock);
    repeat ($urandom_range(50, 200)) @(negedge clock);
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    if (!reset && (data_ready || frame_error)) begin
      if (data_ready && frame_error) begin
        n_vec++;
        n_err++;
        $display("FAIL both_strobes: got ready=1 error=1, expected only one");
      end else if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got err=%0b data=%02h, expected no strobe",
                 frame_error, data_out);
      end else begin
        check("strobe", {frame_error, data_out}, exp_q.pop_front());
      end
    end
  end

  // main sequence
  initial begin
    logic [7:0] b;
    int         kind;
    n_vec      = 0;
    n_err      = 0;
    model_dout = 8'h00;
    reset      = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    do_reset(5);
    @(negedge clock);
    check("reset_data_out", {1'b0, data_out}, 9'h000);
    check("reset_ready", {8'h00, data_ready}, 9'h000);
    check("reset_error", {8'h00, frame_error}, 9'h000);
    repeat (50) @(negedge clock);

    // directed cases
    issue_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11, 1'b0);
    issue_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11, 1'b0);
    issue_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11, 1'b0);
    issue_frame(8'h1C, 1'b1, 1'b1, 1'b0, 11, 1'b0);
    issue_frame(8'hA7, good_par(8'hA7), 1'b1, 1'b0, 11, 1'b1);
    issue_frame(8'h33, good_par(8'h33), 1'b0, 1'b0, 11, 1'b0);
    issue_frame(8'h00, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    issue_frame(8'h96, 1'b0, 1'b1, 1'b0, 5, 1'b0);
    issue_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b0, 11, 1'b0);

    // reset mid-frame: no strobe expected, output returns to 0
    send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 6, 1'b0);
    do_reset(3);
    model_dout = 8'h00;
    @(negedge clock);
    check("midreset_data_out", {1'b0, data_out}, 9'h000);
    repeat (50) @(negedge clock);
    issue_frame(8'h29, good_par(8'h29), 1'b1, 1'b0, 11, 1'b0);

    // randomized frames
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      case (kind)
        0: issue_frame(b, ~good_par(b), 1'b1, 1'b0, 11, 1'($urandom_range(0, 1)));
        1: issue_frame(b, good_par(b), 1'b0, 1'b0, 11, 1'b0);
        2: issue_frame(b, good_par(b), 1'b1, 1'b0, $urandom_range(2, 9), 1'b0);
        3: issue_frame(b, good_par(b), 1'b1, 1'b1, 1, 1'b0);
        default: issue_frame(b, good_par(b), 1'b1, 1'b0, 11, 1'($urandom_range(0, 1)));
      endcase
    end

    repeat (200) @(negedge clock);
    check("pending_expected", 9'(exp_q.size()), 9'h000);
    check("final_data_out", {1'b0, data_out}, {1'b0, model_dout});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
